// File: rtl/flash_port_arbiter.sv
// Two-port (instruction fetch / data load) arbiter in front of a shared SPI flash
// reader, with round-robin tie-break, abort on request drop and transaction timeout.
module flash_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TW             = 13,
  localparam int unsigned XLEN          = 32
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            i_req_i,
  input  logic [XLEN-1:0] i_addr_i,
  output logic            i_rvalid_o,
  output logic [XLEN-1:0] i_rdata_o,
  output logic            i_err_o,
  input  logic            d_req_i,
  input  logic [XLEN-1:0] d_addr_i,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            d_err_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_e;

  localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic            gnt_d_q;
  logic [XLEN-1:0] addr_q;
  logic [TW-1:0]   cnt_q;

  logic            pick_d;
  logic            req_gnt;
  logic            grant;
  logic            resp_ok;
  logic            resp_to;

  // gnt_d_q doubles as the round-robin pointer: the current grant is also the last one issued
  assign pick_d  = d_req_i & (~i_req_i | ~gnt_d_q);
  assign req_gnt = gnt_d_q ? d_req_i : i_req_i;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    resp_ok = 1'b0;
    resp_to = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_i || d_req_i) begin
          grant   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_rvalid_i) begin
          resp_ok = 1'b1;
          state_d = GAP;
        end else if (!req_gnt) begin
          state_d = GAP;
        end else if (cnt_q == LAST_CNT) begin
          resp_to = 1'b1;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      gnt_d_q    <= 1'b1;
      addr_q     <= '0;
      cnt_q      <= '0;
      i_rvalid_o <= 1'b0;
      i_err_o    <= 1'b0;
      i_rdata_o  <= '0;
      d_rvalid_o <= 1'b0;
      d_err_o    <= 1'b0;
      d_rdata_o  <= '0;
    end else begin
      if (grant) begin
        gnt_d_q <= pick_d;
        addr_q  <= pick_d ? d_addr_i : i_addr_i;
        cnt_q   <= '0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + TW'(1);
      end
      i_rvalid_o <= (resp_ok | resp_to) & ~gnt_d_q;
      i_err_o    <= resp_to & ~gnt_d_q;
      d_rvalid_o <= (resp_ok | resp_to) & gnt_d_q;
      d_err_o    <= resp_to & gnt_d_q;
      if ((resp_ok || resp_to) && !gnt_d_q) i_rdata_o <= resp_ok ? mem_rdata_i : '0;
      if ((resp_ok || resp_to) && gnt_d_q)  d_rdata_o <= resp_ok ? mem_rdata_i : '0;
    end
  end

  assign mem_req_o  = (state_q == BUSY);
  assign mem_addr_o = mem_req_o ? addr_q : '0;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Directed bench for flash_port_arbiter: u_dut uses default timeout, u_dut_to a
// 16-cycle timeout for the timeout scenarios; both share the same inputs.
module tb_flash_port_arbiter;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        i_req_i = 1'b0, d_req_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] i_addr_i = '0, d_addr_i = '0, mem_rdata_i = '0;

  logic        i_rvalid_o, i_err_o, d_rvalid_o, d_err_o, mem_req_o, busy_o;
  logic [31:0] i_rdata_o, d_rdata_o, mem_addr_o;
  logic        t_i_rvalid_o, t_i_err_o, t_d_rvalid_o, t_d_err_o, t_mem_req_o, t_busy_o;
  logic [31:0] t_i_rdata_o, t_d_rdata_o, t_mem_addr_o;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned i_pulses = 0, d_pulses = 0;

  always #5 clk_i = ~clk_i;

  flash_port_arbiter u_dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rvalid_o(i_rvalid_o),
    .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  flash_port_arbiter #(.TIMEOUT_CYCLES(16), .TW(5)) u_dut_to (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rvalid_o(t_i_rvalid_o),
    .i_rdata_o(t_i_rdata_o), .i_err_o(t_i_err_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_rvalid_o(t_d_rvalid_o),
    .d_rdata_o(t_d_rdata_o), .d_err_o(t_d_err_o),
    .mem_req_o(t_mem_req_o), .mem_addr_o(t_mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(t_busy_o)
  );

  always @(posedge clk_i) begin
    if (i_rvalid_o) i_pulses <= i_pulses + 1;
    if (d_rvalid_o) d_pulses <= d_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    arstn_i = 1'b0;
    i_req_i = 1'b0; d_req_i = 1'b0; mem_rvalid_i = 1'b0;
    i_addr_i = '0;  d_addr_i = '0;  mem_rdata_i = '0;
    tick(); tick();
    arstn_i = 1'b1;
    tick();
  endtask

  task automatic wait_mem_req(input string tag);
    int unsigned n = 0;
    while (!mem_req_o && n < 8) begin
      tick();
      n++;
    end
    check(tag, {31'b0, mem_req_o}, 32'd1);
  endtask

  int unsigned base_i, base_d;
  logic [31:0] exp_addr;

  initial begin
    do_reset();
    check("rst_mem_req",  {31'b0, mem_req_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_outs", {26'b0, i_rvalid_o, i_err_o, d_rvalid_o, d_err_o, busy_o, t_busy_o}, 32'd0);
    check("rst_rdata", i_rdata_o | d_rdata_o, 32'd0);

    // single fetch, response 80 cycles after the request
    base_d = d_pulses;
    i_req_i = 1'b1; i_addr_i = 32'h100;
    tick();
    check("sf_mem_req",  {31'b0, mem_req_o}, 32'd1);
    check("sf_mem_addr", mem_addr_o, 32'h100);
    repeat (79) tick();
    check("sf_addr_stable", mem_addr_o, 32'h100);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    mem_rvalid_i = 1'b0; i_req_i = 1'b0;
    check("sf_rvalid", {31'b0, i_rvalid_o}, 32'd1);
    check("sf_rdata",  i_rdata_o, 32'hDEADBEEF);
    check("sf_err",    {31'b0, i_err_o}, 32'd0);
    check("sf_gap",    {30'b0, mem_req_o, busy_o}, 32'd1);
    tick();
    check("sf_pulse_1cyc", {31'b0, i_rvalid_o}, 32'd0);
    check("sf_rdata_hold", i_rdata_o, 32'hDEADBEEF);
    check("sf_idle", {31'b0, busy_o}, 32'd0);
    check("sf_no_d_rvalid", d_pulses - base_d, 32'd0);

    // stray flash response while idle is ignored
    base_i = i_pulses;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
    tick();
    mem_rvalid_i = 1'b0;
    tick();
    check("stray_ignored", (i_pulses - base_i) + (d_pulses - base_d), 32'd0);
    check("stray_rdata", i_rdata_o, 32'hDEADBEEF);

    // tie after reset: instruction first, data two cycles after the response
    do_reset();
    i_req_i = 1'b1; d_req_i = 1'b1; i_addr_i = 32'h300; d_addr_i = 32'h400;
    tick();
    check("tie_first_addr", mem_addr_o, 32'h300);
    repeat (3) tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000000A;
    tick();
    mem_rvalid_i = 1'b0; i_req_i = 1'b0;
    check("tie_i_rvalid", {30'b0, i_rvalid_o, d_rvalid_o}, 32'd2);
    check("tie_gap_low", {31'b0, mem_req_o}, 32'd0);
    tick();
    check("tie_idle_low", {31'b0, mem_req_o}, 32'd0);
    tick();
    check("tie_d_granted", {31'b0, mem_req_o}, 32'd1);
    check("tie_d_addr", mem_addr_o, 32'h400);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000000B;
    tick();
    mem_rvalid_i = 1'b0; d_req_i = 1'b0;
    check("tie_d_rvalid", {30'b0, i_rvalid_o, d_rvalid_o}, 32'd1);
    check("tie_d_rdata", d_rdata_o, 32'h0000000B);
    check("tie_i_rdata_hold", i_rdata_o, 32'h0000000A);
    tick();

    // fairness: both held across four transactions -> I, D, I, D
    do_reset();
    i_req_i = 1'b1; d_req_i = 1'b1; i_addr_i = 32'h300; d_addr_i = 32'h400;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 32'h300 : 32'h400;
      wait_mem_req($sformatf("fair_req%0d", k));
      check($sformatf("fair_addr%0d", k), mem_addr_o, exp_addr);
      tick(); tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1000 + k;
      tick();
      mem_rvalid_i = 1'b0;
      check($sformatf("fair_rv%0d", k), {30'b0, i_rvalid_o, d_rvalid_o},
            (k % 2 == 0) ? 32'd2 : 32'd1);
    end
    i_req_i = 1'b0; d_req_i = 1'b0;
    tick(); tick();

    // abort: data request drops ten cycles into BUSY
    do_reset();
    base_d = d_pulses;
    d_req_i = 1'b1; d_addr_i = 32'h500;
    tick();
    check("ab_busy", {31'b0, mem_req_o}, 32'd1);
    repeat (9) tick();
    d_req_i = 1'b0;
    tick();
    check("ab_req_drop", {31'b0, mem_req_o}, 32'd0);
    check("ab_gap_busy", {31'b0, busy_o}, 32'd1);
    tick();
    check("ab_idle", {31'b0, busy_o}, 32'd0);
    tick();
    check("ab_no_rvalid", d_pulses - base_d, 32'd0);

    // timeout=16: same-cycle response wins, then a true timeout
    do_reset();
    d_req_i = 1'b1; d_addr_i = 32'h200;
    tick();
    repeat (15) tick();
    check("to_sc_still_busy", {31'b0, t_mem_req_o}, 32'd1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
    tick();
    mem_rvalid_i = 1'b0; d_req_i = 1'b0;
    check("to_sc_rvalid", {31'b0, t_d_rvalid_o}, 32'd1);
    check("to_sc_err",    {31'b0, t_d_err_o}, 32'd0);
    check("to_sc_rdata",  t_d_rdata_o, 32'h12345678);
    tick();
    d_req_i = 1'b1;
    tick();
    repeat (15) tick();
    check("to_no_early", {30'b0, t_mem_req_o, t_d_rvalid_o}, 32'd2);
    tick();
    check("to_rvalid", {31'b0, t_d_rvalid_o}, 32'd1);
    check("to_err",    {31'b0, t_d_err_o}, 32'd1);
    check("to_rdata",  t_d_rdata_o, 32'd0);
    check("to_gap",    {30'b0, t_mem_req_o, t_i_rvalid_o}, 32'd0);
    d_req_i = 1'b0;
    tick();
    check("to_err_clear", {30'b0, t_d_rvalid_o, t_d_err_o}, 32'd0);

    // reset asserted mid-BUSY, then a fresh fetch
    do_reset();
    base_i = i_pulses;
    i_req_i = 1'b1; i_addr_i = 32'h600;
    tick();
    repeat (3) tick();
    arstn_i = 1'b0;
    #1;
    check("mr_async_req",  {30'b0, mem_req_o, busy_o}, 32'd0);
    check("mr_async_addr", mem_addr_o, 32'd0);
    tick();
    arstn_i = 1'b1;
    check("mr_no_resp", i_pulses - base_i, 32'd0);
    tick();
    check("mr_regrant", {31'b0, mem_req_o}, 32'd1);
    check("mr_addr", mem_addr_o, 32'h600);
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00C0FFEE;
    tick();
    mem_rvalid_i = 1'b0; i_req_i = 1'b0;
    check("mr_rvalid", {31'b0, i_rvalid_o}, 32'd1);
    check("mr_rdata", i_rdata_o, 32'h00C0FFEE);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_port_arbiter.md
FLASH_PORT_ARBITER -- requirements
Module: flash_port_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the maximum cycles one downstream transaction may stay outstanding before it is aborted.
REQ-002 The block SHALL have parameter TW, default 13, giving the width of the timeout counter; TW SHALL be at least clog2(TIMEOUT_CYCLES+1).
REQ-003 The block SHALL have the following ports, with XLEN=32 from rv_pkg:
- clk_i  input  1  clock; all logic rises on the positive edge.
- arstn_i  input  1  reset, asynchronous, active-low.
- i_req_i  input  1  instruction-fetch request, held high until i_rvalid_o.
- i_addr_i  input  XLEN  instruction-fetch byte address.
- i_rvalid_o  output  1  one-cycle response pulse for the instruction port.
- i_rdata_o  output  XLEN  instruction-port read data.
- i_err_o  output  1  instruction-port timeout flag, valid with i_rvalid_o.
- d_req_i, d_addr_i, d_rvalid_o, d_rdata_o, d_err_o  same directions, widths and meanings as above, for the data-load port.
- mem_req_o  output  1  request to the shared SPI flash reader.
- mem_addr_o  output  XLEN  address to the flash reader.
- mem_rvalid_i  input  1  flash reader response pulse.
- mem_rdata_i  input  XLEN  flash reader data.
- busy_o  output  1  high while a transaction is granted or draining.

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY, GAP.
REQ-005 In IDLE with any request high, the block SHALL latch grant and address and enter BUSY on the next edge.
- mem_req_o SHALL be high in the first BUSY cycle.
- Latency from req to mem_req_o SHALL be 1 cycle.
REQ-006 When both requests are high in IDLE, the port not granted last SHALL win (round-robin).
- A single requester SHALL win regardless of history.
REQ-007 mem_req_o SHALL be asserted only in BUSY, and SHALL be high throughout BUSY.
REQ-008 mem_addr_o SHALL be the latched address and SHALL stay stable for all of BUSY; it SHALL be 0 outside BUSY.
REQ-009 mem_rvalid_i in BUSY SHALL cause the following on the next edge:
- mem_rdata_i registered to the granted port's rdata;
- that port's rvalid pulsed high for exactly 1 cycle, with err=0;
- transition to GAP.
REQ-010 mem_rvalid_i outside BUSY SHALL be ignored and SHALL produce no response.
REQ-011 In BUSY, if the granted port's req drops before mem_rvalid_i, the block SHALL go to GAP with no response (abort).
- mem_req_o dropping SHALL cause the flash reader to return to idle.
REQ-012 The timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle.
- On reaching TIMEOUT_CYCLES without mem_rvalid_i, the block SHALL go to GAP and pulse rvalid=1, err=1, rdata=0 to the granted port.
REQ-013 If mem_rvalid_i and the timeout occur in the same cycle, mem_rvalid_i SHALL take priority and err SHALL be 0.
REQ-014 GAP SHALL last exactly 1 cycle with mem_req_o=0, then return to IDLE.
- Consecutive transactions SHALL therefore be separated by at least 2 cycles of mem_req_o low (GAP plus IDLE).
REQ-015 The round-robin pointer SHALL update only when a grant is issued.
REQ-016 The non-granted port SHALL never see rvalid.
- Its request SHALL stay pending until a later grant.
REQ-017 rdata outputs SHALL hold their last value after the rvalid pulse.
REQ-018 busy_o SHALL be high in BUSY and GAP.

Reset
REQ-019 While arstn_i is low, the block SHALL hold:
- state IDLE;
- mem_req_o=0, mem_addr_o=0;
- all rvalid, err, rdata outputs and busy_o = 0;
- timeout counter 0;
- round-robin pointer "data granted last", so the instruction port wins the first tie.
REQ-020 Reset asserted mid-BUSY SHALL drop mem_req_o asynchronously and produce no response after release.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single fetch: i_req_i=1, i_addr_i=0x100; mem_rvalid_i 80 cycles later with 0xDEADBEEF -> mem_addr_o=0x100, i_rvalid_o pulse 1 cycle, i_rdata_o=0xDEADBEEF, i_err_o=0, d_rvalid_o never high.
- Tie after reset: i_req_i and d_req_i high together -> instruction served first; data granted 2 cycles after the instruction response; mem_req_o low for at least 2 cycles between the two.
- Fairness: both requests held high continuously across 4 transactions -> grants alternate I, D, I, D.
- Abort: d_req_i drops 10 cycles into BUSY -> mem_req_o=0 next cycle, no d_rvalid_o, back to IDLE after GAP.
- Timeout: TIMEOUT_CYCLES=16, mem_rvalid_i never asserted -> after 16 BUSY cycles d_rvalid_o=1, d_err_o=1, d_rdata_o=0; same-cycle mem_rvalid_i variant -> err=0, data delivered.
- Reset mid-transaction: arstn_i low during BUSY -> all outputs 0 immediately; after release, a new i_req_i is served normally.
